in_port_ctrl: RTL and testbench

- Input-side counterpart to the CPU's output port.
- Accepts words from an external device over an asynchronous 4-phase strobe/ack handshake and buffers them in a small FIFO.
- Presents the head word to the datapath bus mux; the "in" instruction's InPort_Out control pops one word per assertion.

---
 rtl/inport_defs.sv | 14 +
 rtl/sync_ff.sv | 29 ++
 rtl/in_port_ctrl.sv | 166 ++++++++++++++++
 tb/tb_in_port_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inport_defs.sv
// rtl/inport_defs.sv - shared constants and FSM encoding for the input port controller
package inport_defs;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        ACK        = 2'b01,
        WAIT_SPACE = 2'b10
    } inport_state_e;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-stage single-bit synchronizer with asynchronous active-high clear
//
// Ports:
//   Clock - destination clock domain
//   Clear - asynchronous active-high reset, forces every stage to 0
//   d_i   - asynchronous input bit
//   q_o   - synchronized output, d_i delayed by N rising edges
module sync_ff #(
    parameter int N = 2
) (
    input  logic Clock,
    input  logic Clear,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/in_port_ctrl.sv
// rtl/in_port_ctrl.sv - input port: 4-phase strobe/ack capture into a show-ahead FIFO
//
// Ports:
//   Clock        - system clock, rising edge
//   Clear        - asynchronous active-high reset
//   Ext_Data     - device data, stable while Ext_Strobe is high
//   Ext_Strobe   - device request, asynchronous to Clock
//   Ext_Ack      - registered acknowledge to the device
//   InPort_Out   - datapath control: drive bus and pop this cycle
//   InPort_Data  - head word (0 when empty)
//   InPort_Valid - FIFO not empty
//   InPort_Full  - FIFO holds DEPTH words
//   Underflow    - sticky pop-while-empty flag (only with INPORT_UNDERFLOW_EN)
//
// Optional feature macro: INPORT_UNDERFLOW_EN
module in_port_ctrl
    import inport_defs::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Ext_Data,
    input  logic             Ext_Strobe,
    output logic             Ext_Ack,
    input  logic             InPort_Out,
    output logic [WIDTH-1:0] InPort_Data,
    output logic             InPort_Valid,
    output logic             InPort_Full
`ifdef INPORT_UNDERFLOW_EN
    ,
    output logic             Underflow
`endif
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    inport_state_e state_q, state_d;
    logic          ack_q, ack_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic s_strobe;
    logic wr_en;
    logic pop;
    logic full;
    logic valid;

    sync_ff #(
        .N (SYNC_STAGES)
    ) u_strobe_sync (
        .Clock (Clock),
        .Clear (Clear),
        .d_i   (Ext_Strobe),
        .q_o   (s_strobe)
    );

    assign full  = (count_q == FULL_CNT);
    assign valid = (count_q != '0);
    // Pop is qualified by the registered count, so a word written this edge
    // into an empty FIFO cannot be popped until the following cycle.
    assign pop   = InPort_Out && valid;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_strobe) begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                // full is from the registered count, so space freed by a pop
                // is only seen one edge after that pop.
                if (!full) begin
                    wr_en   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!s_strobe) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible while count is nonzero.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= Ext_Data;
        end
    end

    assign Ext_Ack      = ack_q;
    assign InPort_Valid = valid;
    assign InPort_Full  = full;
    assign InPort_Data  = valid ? mem_q[rd_ptr_q] : '0;

`ifdef INPORT_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            underflow_q <= 1'b0;
        end else if (InPort_Out && !valid) begin
            underflow_q <= 1'b1;
        end
    end

    assign Underflow = underflow_q;
`endif

endmodule

// File: tb/tb_in_port_ctrl.sv
// tb/tb_in_port_ctrl.sv - self-checking bench for in_port_ctrl with a queue reference model
module tb_in_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ext_data;
    logic        ext_strobe;
    logic        ext_ack;
    logic        in_out;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_full;
`ifdef INPORT_UNDERFLOW_EN
    logic        underflow;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    in_port_ctrl dut (
        .Clock        (clk),
        .Clear        (rst),
        .Ext_Data     (ext_data),
        .Ext_Strobe   (ext_strobe),
        .Ext_Ack      (ext_ack),
        .InPort_Out   (in_out),
        .InPort_Data  (in_data),
        .InPort_Valid (in_valid),
        .InPort_Full  (in_full)
`ifdef INPORT_UNDERFLOW_EN
        ,
        .Underflow    (underflow)
`endif
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_clear();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_q.delete();
    endtask

    task automatic wait_ack(input logic lvl, input string nm);
        int k = 0;
        while (ext_ack !== lvl && k < 20) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (ext_ack !== lvl) $display("FAIL %s: Ext_Ack got %b expected %b within 20 cycles", nm, ext_ack, lvl);
        else n_pass++;
    endtask

    task automatic handshake(input logic [31:0] d);
        ext_data   = d;
        ext_strobe = 1'b1;
        wait_ack(1'b1, "hs_ack_rise");
        model_q.push_back(d);
        ext_strobe = 1'b0;
        wait_ack(1'b0, "hs_ack_fall");
    endtask

    task automatic pop_check(input string nm);
        logic [31:0] exp_d;
        exp_d = (model_q.size() != 0) ? model_q[0] : 32'h0;
        n_checks++;
        if (in_data !== exp_d || in_valid !== (model_q.size() != 0))
            $display("FAIL %s: data %h valid %b expected data %h valid %b", nm, in_data, in_valid, exp_d, model_q.size() != 0);
        else n_pass++;
        in_out = 1'b1;
        tick(1);
        in_out = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    task automatic test_reset();
        rst = 1'b1; ext_data = '0; ext_strobe = 1'b0; in_out = 1'b0;
        tick(2);
        n_checks++;
        if (ext_ack !== 1'b0 || in_valid !== 1'b0 || in_full !== 1'b0 || in_data !== 32'h0)
            $display("FAIL reset: ack %b valid %b full %b data %h expected 0 0 0 0", ext_ack, in_valid, in_full, in_data);
        else n_pass++;
        rst = 1'b0;
        model_q.delete();
    endtask

    task automatic test_single_word();
        do_clear();
        ext_data = 32'h55; ext_strobe = 1'b1;
        tick(2);
        n_checks++;
        if (ext_ack !== 1'b0) $display("FAIL single_early_ack: got %b expected 0", ext_ack); else n_pass++;
        tick(1);
        n_checks++;
        if (ext_ack !== 1'b1 || in_valid !== 1'b1)
            $display("FAIL single_latency: ack %b valid %b expected 1 1", ext_ack, in_valid);
        else n_pass++;
        model_q.push_back(32'h55);
        ext_strobe = 1'b0;
        tick(2);
        n_checks++;
        if (ext_ack !== 1'b1) $display("FAIL single_ack_hold: got %b expected 1", ext_ack); else n_pass++;
        tick(1);
        n_checks++;
        if (ext_ack !== 1'b0) $display("FAIL single_ack_fall: got %b expected 0", ext_ack); else n_pass++;
        pop_check("single_pop");
        n_checks++;
        if (in_valid !== 1'b0 || in_data !== 32'h0)
            $display("FAIL single_after_pop: valid %b data %h expected 0 0", in_valid, in_data);
        else n_pass++;
    endtask

    task automatic test_fill();
        do_clear();
        handshake(32'h11); handshake(32'h22); handshake(32'h33); handshake(32'h44);
        n_checks++;
        if (in_full !== 1'b1) $display("FAIL fill_full: got %b expected 1", in_full); else n_pass++;
        ext_data = 32'h55; ext_strobe = 1'b1;
        tick(6);
        n_checks++;
        if (ext_ack !== 1'b0) $display("FAIL fill_wait_ack: got %b expected 0", ext_ack); else n_pass++;
        pop_check("fill_pop_first");
        n_checks++;
        if (in_full !== 1'b0 || ext_ack !== 1'b0)
            $display("FAIL fill_after_pop: full %b ack %b expected 0 0", in_full, ext_ack);
        else n_pass++;
        tick(1);
        model_q.push_back(32'h55);
        n_checks++;
        if (ext_ack !== 1'b1 || in_full !== 1'b1)
            $display("FAIL fill_deferred_write: ack %b full %b expected 1 1", ext_ack, in_full);
        else n_pass++;
        ext_strobe = 1'b0;
        wait_ack(1'b0, "fill_ack_fall");
        for (int i = 0; i < 4; i++) pop_check("fill_drain");
        n_checks++;
        if (in_valid !== 1'b0) $display("FAIL fill_empty: valid %b expected 0", in_valid); else n_pass++;
    endtask

    task automatic test_concurrent();
        do_clear();
        handshake(32'hA0);
        ext_data = 32'hB0; ext_strobe = 1'b1;
        tick(2);
        pop_check("conc_pop_a0");
        model_q.push_back(32'hB0);
        n_checks++;
        if (ext_ack !== 1'b1 || in_valid !== 1'b1 || in_full !== 1'b0 || in_data !== 32'hB0)
            $display("FAIL conc_state: ack %b valid %b full %b data %h expected 1 1 0 b0", ext_ack, in_valid, in_full, in_data);
        else n_pass++;
        ext_strobe = 1'b0;
        wait_ack(1'b0, "conc_ack_fall");
        pop_check("conc_pop_b0");
        n_checks++;
        if (in_valid !== 1'b0) $display("FAIL conc_count: valid %b expected 0", in_valid); else n_pass++;
    endtask

    task automatic test_empty_read();
        do_clear();
        in_out = 1'b1;
        tick(1);
        in_out = 1'b0;
        n_checks++;
        if (in_data !== 32'h0 || in_valid !== 1'b0)
            $display("FAIL empty_read: data %h valid %b expected 0 0", in_data, in_valid);
        else n_pass++;
`ifdef INPORT_UNDERFLOW_EN
        n_checks++;
        if (underflow !== 1'b1) $display("FAIL underflow_set: got %b expected 1", underflow); else n_pass++;
`endif
        handshake(32'h77);
        pop_check("empty_then_word");
`ifdef INPORT_UNDERFLOW_EN
        n_checks++;
        if (underflow !== 1'b1) $display("FAIL underflow_sticky: got %b expected 1", underflow); else n_pass++;
        do_clear();
        n_checks++;
        if (underflow !== 1'b0) $display("FAIL underflow_clear: got %b expected 0", underflow); else n_pass++;
`endif
    endtask

    task automatic test_clear_mid();
        do_clear();
        handshake(32'h1); handshake(32'h2);
        ext_data = 32'hC1; ext_strobe = 1'b1;
        wait_ack(1'b1, "mid_ack_rise");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_q.delete();
        n_checks++;
        if (ext_ack !== 1'b0 || in_valid !== 1'b0 || in_full !== 1'b0 || in_data !== 32'h0)
            $display("FAIL mid_clear: ack %b valid %b full %b data %h expected 0 0 0 0", ext_ack, in_valid, in_full, in_data);
        else n_pass++;
        @(posedge clk);
        #2 rst = 1'b0;
        tick(2);
        n_checks++;
        if (ext_ack !== 1'b0) $display("FAIL mid_early_ack: got %b expected 0", ext_ack); else n_pass++;
        tick(1);
        n_checks++;
        if (ext_ack !== 1'b1) $display("FAIL mid_recapture: ack got %b expected 1", ext_ack); else n_pass++;
        model_q.push_back(32'hC1);
        ext_strobe = 1'b0;
        wait_ack(1'b0, "mid_ack_fall");
        pop_check("mid_pop");
        n_checks++;
        if (in_valid !== 1'b0) $display("FAIL mid_one_word: valid %b expected 0", in_valid); else n_pass++;
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 2);
            if (r == 0 && model_q.size() < 4) handshake($urandom);
            else if (r != 2 || model_q.size() == 4) pop_check("rand_pop");
            else tick($urandom_range(1, 3));
            n_checks++;
            if (in_full !== (model_q.size() == 4) || in_valid !== (model_q.size() != 0))
                $display("FAIL rand_flags: full %b valid %b expected %b %b", in_full, in_valid, model_q.size() == 4, model_q.size() != 0);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_concurrent();
        test_empty_read();
        test_clear_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
